instr_mem_pipelined: RTL and testbench

- Parametrised successor to the instruction memory: word-organised, byte-addressed instruction store with a configurable-latency read pipeline and a valid/ready handshake toward fetch.
- Adds a byte-enabled write port for program loading and a post-reset init sequencer that fills every word with the NOP encoding.
- Flags misaligned and out-of-range fetches.
- Sits between the IF-stage PC logic and the IF/ID pipeline register.

---
 rtl/instr_mem_pipelined_if.sv | 34 +++
 rtl/instr_mem_pipelined.sv | 146 ++++++++++++++
 tb/tb_instr_mem_pipelined.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_pipelined_if.sv
// Fetch/load bus for the pipelined instruction memory.
// Master is the IF-stage side; slave is the memory.
interface instr_mem_pipelined_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int WORD_WIDTH = 32
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_accept;
  logic                  rd_valid;
  logic                  rd_ready;
  logic [WORD_WIDTH-1:0] rd_data;
  logic                  rd_misaligned;
  logic                  rd_oob;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WORD_WIDTH-1:0] wr_data;
  logic [3:0]            wr_be;
  logic                  wr_drop;

  modport master (
    output rd_req, rd_addr, rd_ready,
    output wr_en, wr_addr, wr_data, wr_be,
    input  rd_accept, rd_valid, rd_data,
    input  rd_misaligned, rd_oob, wr_drop
  );

  modport slave (
    input  rd_req, rd_addr, rd_ready,
    input  wr_en, wr_addr, wr_data, wr_be,
    output rd_accept, rd_valid, rd_data,
    output rd_misaligned, rd_oob, wr_drop
  );
endinterface

// File: rtl/instr_mem_pipelined.sv
// Word-organised instruction store with NOP fill after reset,
// byte-enabled load port and a stallable read pipeline.
module instr_mem_pipelined #(
  parameter int WORD_WIDTH   = 32,
  parameter int DEPTH_WORDS  = 64,
  parameter int ADDR_WIDTH   = 32,
  parameter int READ_LATENCY = 1,
  parameter logic [WORD_WIDTH-1:0] NOP_WORD = 32'hE000_0000
) (
  input  logic clk,
  input  logic rst,
  instr_mem_pipelined_if.slave bus,
  output logic init_done
);

  localparam int IW = $clog2(DEPTH_WORDS);
  localparam int XW = ADDR_WIDTH - 2;
  localparam int LS = READ_LATENCY - 1;

  typedef enum logic {
    ST_INIT,
    ST_READY
  } state_t;

  typedef struct packed {
    logic                  v;
    logic                  mis;
    logic                  oob;
    logic [WORD_WIDTH-1:0] d;
  } stage_t;

  state_t         state_q;
  state_t         state_d;
  logic [IW-1:0]  cnt_q;
  logic [IW-1:0]  cnt_d;
  logic           ready;

  logic [WORD_WIDTH-1:0] mem [DEPTH_WORDS];

  stage_t         pipe [READ_LATENCY];
  stage_t         in_st;
  logic           advance;
  logic           accept;
  logic [XW-1:0]  rd_idx;
  logic           rd_oob;

  logic [XW-1:0]  wr_idx;
  logic           wr_oob;
  logic           wr_hit;
  logic           drop_q;
  logic           unused_wr_lsb;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      ST_INIT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == IW'(DEPTH_WORDS - 1))
          state_d = ST_READY;
      end
      ST_READY: ;
    endcase
  end

  assign ready     = (state_q == ST_READY);
  assign init_done = ready;

  assign rd_idx  = bus.rd_addr[ADDR_WIDTH-1:2];
  assign rd_oob  = (rd_idx >= XW'(DEPTH_WORDS));
  assign advance = !pipe[LS].v | bus.rd_ready;
  assign accept  = bus.rd_req & ready & advance;

  always_comb begin
    in_st.v   = 1'b0;
    in_st.mis = 1'b0;
    in_st.oob = 1'b0;
    in_st.d   = NOP_WORD;
    if (accept) begin
      in_st.v   = 1'b1;
      in_st.mis = |bus.rd_addr[1:0];
      in_st.oob = rd_oob;
      if (!rd_oob)
        in_st.d = mem[rd_idx[IW-1:0]];
    end
  end

  // The whole pipe moves as one; a stall freezes every stage.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        pipe[i].v   <= 1'b0;
        pipe[i].mis <= 1'b0;
        pipe[i].oob <= 1'b0;
        pipe[i].d   <= NOP_WORD;
      end
    end else if (advance) begin
      pipe[0] <= in_st;
      for (int i = 1; i < READ_LATENCY; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign bus.rd_accept     = accept;
  assign bus.rd_valid      = pipe[LS].v;
  assign bus.rd_data       = pipe[LS].d;
  assign bus.rd_misaligned = pipe[LS].mis;
  assign bus.rd_oob        = pipe[LS].oob;

  assign wr_idx = bus.wr_addr[ADDR_WIDTH-1:2];
  assign wr_oob = (wr_idx >= XW'(DEPTH_WORDS));
  assign wr_hit = bus.wr_en & ready & !wr_oob;

  assign unused_wr_lsb = ^bus.wr_addr[1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      drop_q <= 1'b0;
    else
      drop_q <= bus.wr_en & (!ready | wr_oob);
  end

  assign bus.wr_drop = drop_q;

  // Array is not reset; the fill sequencer owns it until READY.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem[cnt_q] <= NOP_WORD;
    end else if (wr_hit) begin
      for (int b = 0; b < 4; b++)
        if (bus.wr_be[b])
          mem[wr_idx[IW-1:0]][b*8 +: 8] <= bus.wr_data[b*8 +: 8];
    end
  end

endmodule

// File: tb/tb_instr_mem_pipelined.sv
// Randomised bench for instr_mem_pipelined against a word-array
// model and an in-order expectation queue.
module tb_instr_mem_pipelined;

  localparam int DEPTH = 64;
  localparam int LAT   = 3;
  localparam logic [31:0] NOP = 32'hE000_0000;

  typedef struct {
    logic [31:0] d;
    logic        mis;
    logic        oob;
    int          acc;
  } exp_t;

  logic clk;
  logic rst;
  logic init_done;

  instr_mem_pipelined_if #(.ADDR_WIDTH(32), .WORD_WIDTH(32)) bus ();

  instr_mem_pipelined #(
    .WORD_WIDTH(32),
    .DEPTH_WORDS(DEPTH),
    .ADDR_WIDTH(32),
    .READ_LATENCY(LAT),
    .NOP_WORD(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave),
    .init_done(init_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] mdl [DEPTH];
  exp_t        q [$];
  int          n_chk;
  int          n_fail;
  int          cyc;
  int          rel;
  int          last_stall;
  bit          head_seen;
  bit          hold_pend;
  bit          drop_pend;
  bit          acc_s;
  logic [31:0] hold_d;
  logic [31:0] last_pop;
  logic        last_mis;
  logic        last_oob;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One bus cycle: sample just after the falling edge, then let the
  // rising edge happen and return at the next falling edge.
  task automatic tick();
    bit          done_e;
    exp_t        e;
    logic [29:0] idx;
    #1;
    if (!rst) begin
      chk("rst_valid", bus.rd_valid, 0);
      chk("rst_data", bus.rd_data, NOP);
      chk("rst_mis", bus.rd_misaligned, 0);
      chk("rst_oob", bus.rd_oob, 0);
      chk("rst_accept", bus.rd_accept, 0);
      chk("rst_drop", bus.wr_drop, 0);
      chk("rst_done", init_done, 0);
      q.delete();
      head_seen  = 0;
      hold_pend  = 0;
      drop_pend  = 0;
      acc_s      = 0;
      rel        = 0;
      last_stall = cyc;
      for (int i = 0; i < DEPTH; i++) mdl[i] = NOP;
    end else begin
      done_e = (rel >= DEPTH);
      chk("init_done", init_done, done_e);
      chk("wr_drop", bus.wr_drop, drop_pend);
      if (hold_pend) begin
        chk("hold_valid", bus.rd_valid, 1);
        chk("hold_data", bus.rd_data, hold_d);
      end
      hold_pend = 0;
      if (bus.rd_valid) begin
        if (q.size() == 0) begin
          chk("spurious_valid", bus.rd_valid, 0);
        end else begin
          if (!head_seen && q[0].acc > last_stall)
            chk("latency", cyc - q[0].acc, LAT);
          head_seen = 1;
          if (bus.rd_ready) begin
            e = q.pop_front();
            chk("rd_data", bus.rd_data, e.d);
            chk("rd_mis", bus.rd_misaligned, e.mis);
            chk("rd_oob", bus.rd_oob, e.oob);
            last_pop  = bus.rd_data;
            last_mis  = bus.rd_misaligned;
            last_oob  = bus.rd_oob;
            head_seen = 0;
          end else begin
            last_stall = cyc;
            hold_pend  = 1;
            hold_d     = bus.rd_data;
          end
        end
      end
      if (bus.rd_req)
        chk("accept", bus.rd_accept,
            done_e && (!bus.rd_valid || bus.rd_ready));
      else
        chk("accept_idle", bus.rd_accept, 0);
      acc_s = bus.rd_accept;
      if (bus.rd_accept) begin
        idx   = bus.rd_addr[31:2];
        e.oob = (idx >= DEPTH);
        e.d   = e.oob ? NOP : mdl[idx[5:0]];
        e.mis = (bus.rd_addr[1:0] != 0);
        e.acc = cyc;
        q.push_back(e);
      end
      // Writes land after the read above: read-before-write.
      drop_pend = 0;
      if (bus.wr_en) begin
        idx = bus.wr_addr[31:2];
        if (!done_e || idx >= DEPTH)
          drop_pend = 1;
        else
          for (int b = 0; b < 4; b++)
            if (bus.wr_be[b])
              mdl[idx[5:0]][b*8 +: 8] = bus.wr_data[b*8 +: 8];
      end
      rel++;
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic issue(input logic [31:0] a);
    bus.rd_req  = 1;
    bus.rd_addr = a;
    acc_s = 0;
    for (int i = 0; i < 50 && !acc_s; i++) tick();
    if (!acc_s) chk("accept_timeout", acc_s, 1);
    bus.rd_req = 0;
  endtask

  task automatic drain();
    bus.rd_req   = 0;
    bus.wr_en    = 0;
    bus.rd_ready = 1;
    for (int i = 0; i < 30 && q.size() > 0; i++) tick();
    if (q.size() != 0) chk("drain", q.size(), 0);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d,
                    input logic [3:0] be);
    bus.wr_en   = 1;
    bus.wr_addr = a;
    bus.wr_data = d;
    bus.wr_be   = be;
    tick();
    bus.wr_en = 0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 200 && rel <= DEPTH; i++) tick();
  endtask

  initial begin
    int n;
    n_chk = 0; n_fail = 0; cyc = 0; rel = 0; last_stall = 0;
    bus.rd_req = 1; bus.rd_addr = 0; bus.rd_ready = 1;
    bus.wr_en = 0; bus.wr_addr = 0; bus.wr_data = 0; bus.wr_be = 0;
    rst = 0;
    @(negedge clk);
    tick(); tick();
    bus.rd_req = 0;
    rst = 1;
    wait_done();

    issue(32'h0);
    issue(32'hFC);
    drain();
    chk("fill_last_word", last_pop, NOP);

    wr(32'h10, 32'hE3A0_0014, 4'hF);
    wr(32'h10, 32'h1111_2222, 4'b0101);
    issue(32'h10);
    drain();
    chk("byte_merge", last_pop, 32'hE311_0022);

    for (int i = 0; i < 4; i++) wr(i * 4, 32'hA000_0000 + i, 4'hF);
    for (int i = 0; i < 4; i++) issue(i * 4);
    drain();

    n = 0;
    for (int c = 0; c < 14; c++) begin
      bus.rd_ready = !(c == 5 || c == 6);
      bus.rd_req   = (n < 4);
      bus.rd_addr  = n * 4;
      tick();
      if (acc_s) n++;
    end
    drain();
    chk("stall_stream_count", n, 4);

    issue(32'h102);
    drain();
    chk("oob_data", last_pop, NOP);
    chk("oob_flag", last_oob, 1);
    chk("oob_mis", last_mis, 1);
    wr(32'h100, 32'h1234_5678, 4'hF);
    chk("oob_wr_drop", bus.wr_drop, 1);
    issue(32'h0);
    drain();
    chk("oob_no_alias", last_pop, 32'hA000_0000);

    bus.rd_req  = 1; bus.rd_addr = 32'h8;
    bus.wr_en   = 1; bus.wr_addr = 32'h8;
    bus.wr_data = 32'h5555_AAAA; bus.wr_be = 4'hF;
    tick();
    bus.wr_en = 0;
    drain();
    chk("rbw_old", last_pop, 32'hA000_0002);

    for (int c = 0; c < 400; c++) begin
      bus.rd_req   = ($urandom_range(0, 1) == 1);
      bus.rd_addr  = $urandom_range(0, 32'h10F);
      bus.rd_ready = ($urandom_range(0, 3) != 0);
      bus.wr_en    = ($urandom_range(0, 3) == 0);
      bus.wr_addr  = $urandom_range(0, 32'h10F);
      bus.wr_data  = $urandom;
      bus.wr_be    = 4'($urandom_range(0, 15));
      tick();
    end
    drain();

    for (int i = 0; i < 10; i++) tick();
    rst = 0;
    tick(); tick();
    rst = 1;
    for (int i = 0; i < 5; i++) tick();
    wr(32'h20, 32'hDEAD_BEEF, 4'hF);
    wait_done();
    issue(32'h20);
    drain();
    chk("init_wr_absent", last_pop, NOP);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
